// File: rtl/l2_arb_pkg.sv
// Shared types and default sizing for the L2 request arbiter.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StWaitRsp = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, with wrap-around.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx
);

    int unsigned cand;

    // Scan farthest-to-nearest so the nearest active requester is written last and wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ L1 requesters onto a single-outstanding L2 port.
module l2_req_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned IDW            = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   u_req_valid,
    output logic [NUM_REQ-1:0]                   u_req_ready,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   u_req_addr,
    input  logic [NUM_REQ-1:0]                   u_req_we,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   u_req_wdata,
    output logic [NUM_REQ-1:0]                   u_rsp_valid,
    input  logic [NUM_REQ-1:0]                   u_rsp_ready,
    output logic [DATA_WIDTH-1:0]                u_rsp_rdata,
    output logic                                 l2_req_valid,
    output logic [ADDR_WIDTH-1:0]                l2_req_addr,
    output logic                                 l2_req_we,
    output logic [DATA_WIDTH-1:0]                l2_req_wdata,
    input  logic                                 l2_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                l2_rsp_rdata,
    output logic                                 l2_rsp_ready,
    output logic                                 busy,
    output logic [IDW-1:0]                       grant_id,
    output logic                                 timeout_err
);

    arb_state_e            state_q, state_d;
    logic [IDW-1:0]        last_grant_q, grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [15:0]           wdog_q;
    logic                  timeout_q;
    logic [NUM_REQ-1:0]    pick_gnt;
    logic [IDW-1:0]        pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req        (u_req_valid),
        .last_grant (last_grant_q),
        .gnt        (pick_gnt),
        .gnt_idx    (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        u_req_ready  = '0;
        u_rsp_valid  = '0;
        u_rsp_rdata  = '0;
        l2_rsp_ready = 1'b0;
        l2_req_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Gate with rst so the accept stays low while reset is held.
                if (|u_req_valid && !rst) begin
                    u_req_ready = pick_gnt;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                l2_req_valid = 1'b1;
                state_d      = StWaitRsp;
            end
            StWaitRsp: begin
                u_rsp_valid[grant_q] = l2_rsp_valid;
                l2_rsp_ready         = u_rsp_ready[grant_q];
                u_rsp_rdata          = l2_rsp_rdata;
                if (l2_rsp_valid && u_rsp_ready[grant_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= IDW'(NUM_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wdog_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && |u_req_valid) begin
                grant_q <= pick_idx;
                addr_q  <= u_req_addr[pick_idx];
                we_q    <= u_req_we[pick_idx];
                wdata_q <= u_req_wdata[pick_idx];
            end
            if (state_q == StIssue) begin
                wdog_q <= '0;
            end
            if (state_q == StWaitRsp) begin
                if (wdog_q != 16'hffff) begin
                    wdog_q <= wdog_q + 16'd1;
                end
                if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    timeout_q <= 1'b1;
                end
                if (l2_rsp_valid && u_rsp_ready[grant_q]) begin
                    last_grant_q <= grant_q;
                end
            end
        end
    end

    assign busy         = (state_q != StIdle);
    assign grant_id     = grant_q;
    assign timeout_err  = timeout_q;
    assign l2_req_addr  = addr_q;
    assign l2_req_we    = we_q;
    assign l2_req_wdata = wdata_q;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Randomized scoreboard bench for l2_req_arbiter against a transaction-level model.
module tb_l2_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         u_req_valid, u_req_ready, u_req_we, u_rsp_valid, u_rsp_ready;
    logic [N-1:0][AW-1:0] u_req_addr;
    logic [N-1:0][DW-1:0] u_req_wdata;
    logic [DW-1:0]        u_rsp_rdata;
    logic                 l2_req_valid, l2_req_we, l2_rsp_valid, l2_rsp_ready;
    logic [AW-1:0]        l2_req_addr;
    logic [DW-1:0]        l2_req_wdata, l2_rsp_rdata;
    logic                 busy, timeout_err;
    logic [1:0]           grant_id;

    always #5 clk = ~clk;

    l2_req_arbiter #(
        .NUM_REQ        (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .IDW            (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .u_req_valid  (u_req_valid),
        .u_req_ready  (u_req_ready),
        .u_req_addr   (u_req_addr),
        .u_req_we     (u_req_we),
        .u_req_wdata  (u_req_wdata),
        .u_rsp_valid  (u_rsp_valid),
        .u_rsp_ready  (u_rsp_ready),
        .u_rsp_rdata  (u_rsp_rdata),
        .l2_req_valid (l2_req_valid),
        .l2_req_addr  (l2_req_addr),
        .l2_req_we    (l2_req_we),
        .l2_req_wdata (l2_req_wdata),
        .l2_rsp_valid (l2_rsp_valid),
        .l2_rsp_rdata (l2_rsp_rdata),
        .l2_rsp_ready (l2_rsp_ready),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    typedef struct packed {
        logic [1:0]    id;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } req_t;
    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] rdata;
    } rsp_t;

    req_t gnt_q[$];
    req_t l2_q[$];
    rsp_t rsp_q[$];
    int   seen[$];

    int vectors     = 0;
    int miscompares = 0;

    // Per-cycle expectations, published by the stimulus side for the monitor.
    logic [N-1:0]  exp_req_ready = '0, exp_rsp_valid = '0;
    logic          exp_l2_valid = 1'b0, exp_busy = 1'b0, exp_terr = 1'b0, exp_l2rr = 1'b0;
    logic [DW-1:0] exp_rdata = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [1:0]    exp_gid = '0;

    // Transaction-level model: phase 0 = free, 1 = request being sent, 2 = awaiting reply.
    int            m_phase, m_last, m_wait, rsp_wait, mode, hold_cnt;
    req_t          m_cur;
    logic          m_terr, once_done;
    logic [1:0]    m_gid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rdata;
    logic [N-1:0]  just_granted;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    function automatic int winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Monitor: pops expected transactions whenever the DUT presents one.
    always @(negedge clk) begin
        req_t e;
        rsp_t r;
        int   idx;
        check("u_req_ready", u_req_ready, exp_req_ready);
        check("l2_req_valid", l2_req_valid, exp_l2_valid);
        check("busy", busy, exp_busy);
        check("timeout_err", timeout_err, exp_terr);
        check("u_rsp_valid", u_rsp_valid, exp_rsp_valid);
        check("l2_rsp_ready", l2_rsp_ready, exp_l2rr);
        check("u_rsp_rdata", u_rsp_rdata, exp_rdata);
        check("l2_req_addr_live", l2_req_addr, exp_addr);
        check("grant_id", grant_id, exp_gid);
        if (u_req_ready != '0) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (u_req_ready[i]) idx = i;
            seen.push_back(idx);
            if (gnt_q.size() == 0) flag("grant_unexpected");
            else begin
                e = gnt_q.pop_front();
                check("grant_idx", idx, e.id);
            end
        end
        if (l2_req_valid) begin
            if (l2_q.size() == 0) flag("l2_req_unexpected");
            else begin
                e = l2_q.pop_front();
                check("l2_req_addr", l2_req_addr, e.addr);
                check("l2_req_we", l2_req_we, e.we);
                check("l2_req_wdata", l2_req_wdata, e.wdata);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (u_rsp_valid[i] && u_rsp_ready[i]) begin
                if (rsp_q.size() == 0) flag("rsp_unexpected");
                else begin
                    r = rsp_q.pop_front();
                    check("rsp_id", i, r.id);
                    check("rsp_rdata", u_rsp_rdata, r.rdata);
                end
            end
        end
    end

    task automatic new_payload(input int i);
        u_req_addr[i]  = $urandom;
        u_req_we[i]    = 1'($urandom % 2);
        u_req_wdata[i] = $urandom;
    endtask

    task automatic model_reset();
        m_phase = 0; m_last = N - 1; m_wait = 0; m_terr = 1'b0;
        m_gid = '0; m_addr = '0; just_granted = '0;
        gnt_q.delete(); l2_q.delete(); rsp_q.delete(); seen.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: begin
                    if (just_granted[i]) u_req_valid[i] = 1'b0;
                    else if (u_req_valid[i]) begin
                        if ($urandom % 8 == 0) u_req_valid[i] = 1'b0;
                    end else if ($urandom % 3 == 0) begin
                        u_req_valid[i] = 1'b1;
                        new_payload(i);
                    end
                end
                1: begin
                    u_req_valid[i] = 1'b1;
                    if (just_granted[i]) new_payload(i);
                end
                2: u_req_valid[i] = (i == 2) && !once_done && !just_granted[i];
                3: u_req_valid[i] = (i == 0) && !once_done && !just_granted[i];
                default: u_req_valid[i] = 1'b0;
            endcase
        end
        if (m_phase == 2) begin
            if (rsp_wait > 0) begin
                rsp_wait--;
                l2_rsp_valid = 1'b0;
                l2_rsp_rdata = $urandom;
            end else begin
                l2_rsp_valid = 1'b1;
                l2_rsp_rdata = m_rdata;
            end
        end else begin
            l2_rsp_valid = (mode <= 1) && ($urandom % 5 == 0);
            l2_rsp_rdata = $urandom;
        end
        if (mode == 2) begin
            u_rsp_ready    = 4'b1011;
            u_rsp_ready[2] = (hold_cnt >= 4);
            if (m_phase == 2 && l2_rsp_valid) hold_cnt++;
        end else if (mode == 4) u_rsp_ready = '1;
        else u_rsp_ready = 4'($urandom);
    endtask

    task automatic compute();
        int w;
        exp_req_ready = '0; exp_rsp_valid = '0; exp_l2_valid = 1'b0;
        exp_l2rr = 1'b0; exp_rdata = '0;
        if (rst) begin
            model_reset();
            exp_busy = 1'b0; exp_terr = 1'b0; exp_gid = '0; exp_addr = '0;
            return;
        end
        if (m_phase == 2 && m_wait >= TO) m_terr = 1'b1;
        exp_busy = (m_phase != 0);
        exp_terr = m_terr;
        exp_gid  = m_gid;
        exp_addr = m_addr;
        just_granted = '0;
        case (m_phase)
            0: if (|u_req_valid) begin
                w = winner(u_req_valid, m_last);
                exp_req_ready[w] = 1'b1;
                m_cur = '{id: 2'(w), addr: u_req_addr[w], we: u_req_we[w], wdata: u_req_wdata[w]};
                gnt_q.push_back(m_cur);
                l2_q.push_back(m_cur);
                just_granted[w] = 1'b1;
                if (mode == 2 || mode == 3) once_done = 1'b1;
                m_gid = 2'(w); m_addr = m_cur.addr; m_phase = 1;
            end
            1: begin
                exp_l2_valid = 1'b1;
                m_phase = 2; m_wait = 0; m_rdata = $urandom;
                rsp_q.push_back('{id: m_cur.id, rdata: m_rdata});
                rsp_wait = (mode == 3) ? 1000000 : (mode == 2) ? 0 : int'($urandom_range(0, 5));
            end
            default: begin
                exp_rsp_valid[m_cur.id] = l2_rsp_valid;
                exp_l2rr  = u_rsp_ready[m_cur.id];
                exp_rdata = l2_rsp_rdata;
                m_wait++;
                if (l2_rsp_valid && u_rsp_ready[m_cur.id]) begin
                    m_phase = 0; m_last = m_cur.id;
                end
            end
        endcase
    endtask

    task automatic cycle(input bit r);
        @(posedge clk);
        #1;
        rst = r;
        drive();
        if (r) u_req_valid = '1;
        compute();
    endtask

    task automatic drain();
        mode = 4;
        for (int c = 0; c < 200 && m_phase != 0; c++) cycle(0);
        if (m_phase != 0) flag("drain_timeout");
        cycle(0);
    endtask

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        u_req_valid = '0; u_req_addr = '0; u_req_we = '0; u_req_wdata = '0;
        u_rsp_ready = '0; l2_rsp_valid = 1'b0; l2_rsp_rdata = '0;
        mode = 0; hold_cnt = 0; once_done = 1'b0; rsp_wait = 0;
        m_cur = '0; m_rdata = '0;
        model_reset();
        repeat (3) cycle(1);

        // Everyone valid from reset: strict rotation starting at requester 0.
        mode = 1;
        for (int c = 0; c < 300 && seen.size() < 5; c++) cycle(0);
        if (seen.size() < 5) flag("rr_order_timeout");
        else for (int k = 0; k < 5; k++) check($sformatf("rr_order_%0d", k), seen[k], order[k]);

        mode = 0;
        repeat (500) cycle(0);

        // Write held by requester 2 while it back-pressures the response.
        drain();
        mode = 2; hold_cnt = 0; once_done = 1'b0;
        u_req_addr[2] = 32'h40; u_req_we[2] = 1'b1; u_req_wdata[2] = 32'h55;
        for (int c = 0; c < 40 && !(once_done && m_phase == 0); c++) cycle(0);
        if (!(once_done && m_phase == 0)) flag("hold_timeout");

        // Silent L2: watchdog fires but the transaction keeps waiting.
        drain();
        mode = 3; once_done = 1'b0;
        u_req_addr[0] = 32'h100; u_req_we[0] = 1'b0;
        repeat (25) cycle(0);
        check("timeout_sticky", timeout_err, 1);
        check("busy_while_timed_out", busy, 1);

        // Reset mid-wait, then requester 0 must win first.
        cycle(1);
        cycle(1);
        mode = 1;
        for (int c = 0; c < 20 && seen.size() < 1; c++) cycle(0);
        if (seen.size() < 1) flag("post_reset_grant_timeout");
        else check("post_reset_first_grant", seen[0], 0);

        drain();
        @(negedge clk);
        #1;
        check("gnt_q_empty", gnt_q.size(), 0);
        check("l2_q_empty", l2_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
